// File: rtl/lock_pkg.sv
// Shared types and constants for the register-lock controller and its unlock FSM.
package lock_pkg;

   localparam int NUM_LOCKS = 6;
   localparam int DATA_W    = 32;
   localparam int CNT_W     = 8;
   localparam int IDX_W     = 3;

   localparam int                TIMEOUT_DEFAULT = 16;
   localparam logic [DATA_W-1:0] KEY0_DEFAULT    = 32'hA5A5_0001;
   localparam logic [DATA_W-1:0] KEY1_DEFAULT    = 32'h5A5A_0002;

   localparam logic [3:0] ADDR_JTAG_BASE = 4'd6;
   localparam logic [3:0] ADDR_STATUS    = 4'd12;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      ARMED   = 3'd1,
      CLEAR   = 3'd2,
      LOCKOUT = 3'd3
   } state_e;

   // STATUS layout: bits[15:8] counter, bits[2:0] FSM state.
   function automatic logic [DATA_W-1:0] status_word(input state_e state,
                                                      input logic [CNT_W-1:0] count);
      return {16'h0000, count, 5'b00000, state};
   endfunction

endpackage

// File: rtl/lock_reg_ctrl_if.sv
// Request/response bus between a host and the register-lock controller.
interface lock_reg_ctrl_if;
   import lock_pkg::*;

   logic              req_valid;
   logic              req_ready;
   logic              req_we;
   logic [3:0]        req_addr;
   logic [DATA_W-1:0] req_wdata;
   logic              rsp_valid;
   logic [DATA_W-1:0] rsp_rdata;
   logic              rsp_err;

   modport master (
      output req_valid, req_we, req_addr, req_wdata,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_we, req_addr, req_wdata,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );

endinterface

// File: rtl/lock_unlock_fsm.sv
// Two-key unlock sequencer with a shared timeout/lockout counter; emits a
// one-cycle clear pulse while in CLEAR.
module lock_unlock_fsm
   import lock_pkg::*;
#(
   parameter int                TIMEOUT = TIMEOUT_DEFAULT,
   parameter logic [DATA_W-1:0] KEY0    = KEY0_DEFAULT,
   parameter logic [DATA_W-1:0] KEY1    = KEY1_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   input  logic              key_valid_i,
   input  logic [DATA_W-1:0] key_i,
   output state_e            state_o,
   output logic [CNT_W-1:0]  count_o,
   output logic              lock_clear_o
);

   localparam logic [CNT_W-1:0] LOAD = CNT_W'(TIMEOUT - 1);

   // NOTE: state registers use non-blocking assignments so every branch sees
   // the pre-edge values and the simulated behaviour matches the flops.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_o      <= IDLE;
         count_o      <= '0;
         lock_clear_o <= 1'b0;
      end else begin
         lock_clear_o <= 1'b0;
         unique case (state_o)
            IDLE: begin
               if (key_valid_i) begin
                  count_o <= LOAD;
                  state_o <= (key_i == KEY0) ? ARMED : LOCKOUT;
               end
            end
            ARMED: begin
               // KEY1 is still honoured on the cycle the counter reads zero.
               if (key_valid_i && key_i == KEY1) begin
                  state_o      <= CLEAR;
                  count_o      <= '0;
                  lock_clear_o <= 1'b1;
               end else if (key_valid_i) begin
                  state_o <= LOCKOUT;
                  count_o <= LOAD;
               end else if (count_o == '0) begin
                  state_o <= IDLE;
               end else begin
                  count_o <= count_o - 1'b1;
               end
            end
            CLEAR: begin
               state_o <= IDLE;
            end
            LOCKOUT: begin
               if (count_o == '0) state_o <= IDLE;
               else               count_o <= count_o - 1'b1;
            end
            default: begin
               state_o <= IDLE;
               count_o <= '0;
            end
         endcase
      end
   end

endmodule

// File: rtl/lock_reg_ctrl.sv
// Register-lock controller: W1S lock arrays behind a one-cycle-latency bus,
// cleared only by reset or a successful two-key unlock.
module lock_reg_ctrl
   import lock_pkg::*;
#(
   parameter int                TIMEOUT = TIMEOUT_DEFAULT,
   parameter logic [DATA_W-1:0] KEY0    = KEY0_DEFAULT,
   parameter logic [DATA_W-1:0] KEY1    = KEY1_DEFAULT
) (
   input  logic              clk_i,
   input  logic              rst_ni,
   lock_reg_ctrl_if.slave    bus,
   input  logic              key_valid_i,
   input  logic [DATA_W-1:0] key_i,
   output logic [DATA_W-1:0] register_lcks_o [NUM_LOCKS],
   output logic [DATA_W-1:0] jtag_lock_o     [NUM_LOCKS],
   output logic              lock_clear_o
);

   state_e            state;
   logic [CNT_W-1:0]  count;
   logic              accept;
   logic              bad;
   logic              wr_reg;
   logic              wr_jtag;
   logic [IDX_W-1:0]  idx;
   logic [DATA_W-1:0] rd_data;

   lock_unlock_fsm #(
      .TIMEOUT (TIMEOUT),
      .KEY0    (KEY0),
      .KEY1    (KEY1)
   ) u_fsm (
      .clk_i        (clk_i),
      .rst_ni       (rst_ni),
      .key_valid_i  (key_valid_i),
      .key_i        (key_i),
      .state_o      (state),
      .count_o      (count),
      .lock_clear_o (lock_clear_o)
   );

   assign bus.req_ready = (state != CLEAR);
   assign accept        = bus.req_valid && bus.req_ready;

   // NOTE: every signal gets a default before the decode so no path through
   // this block can leave one unassigned and infer a latch.
   always_comb begin
      rd_data = '0;
      bad     = 1'b0;
      wr_reg  = 1'b0;
      wr_jtag = 1'b0;
      idx     = '0;
      if (bus.req_addr < ADDR_JTAG_BASE) begin
         idx     = bus.req_addr[IDX_W-1:0];
         rd_data = register_lcks_o[idx];
         wr_reg  = bus.req_we;
      end else if (bus.req_addr < ADDR_STATUS) begin
         idx     = IDX_W'(bus.req_addr - ADDR_JTAG_BASE);
         rd_data = jtag_lock_o[idx];
         wr_jtag = bus.req_we;
      end else if (bus.req_addr == ADDR_STATUS) begin
         rd_data = status_word(state, count);
         bad     = bus.req_we;
      end else begin
         bad = 1'b1;
      end
   end

   // NOTE: the lock arrays are reset explicitly; they are security state and
   // must come up all-zero, unlike a plain storage RAM.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < NUM_LOCKS; i++) begin
            register_lcks_o[i] <= '0;
            jtag_lock_o[i]     <= '0;
         end
         bus.rsp_valid <= 1'b0;
         bus.rsp_rdata <= '0;
         bus.rsp_err   <= 1'b0;
      end else begin
         bus.rsp_valid <= accept;
         bus.rsp_err   <= accept && bad;
         bus.rsp_rdata <= (accept && !bus.req_we && !bad) ? rd_data : '0;

         // The clear pulse wins over any write landing in the same cycle.
         if (lock_clear_o) begin
            for (int i = 0; i < NUM_LOCKS; i++) begin
               register_lcks_o[i] <= '0;
               jtag_lock_o[i]     <= '0;
            end
         end else if (accept && wr_reg) begin
            register_lcks_o[idx] <= register_lcks_o[idx] | bus.req_wdata;
         end else if (accept && wr_jtag) begin
            jtag_lock_o[idx] <= jtag_lock_o[idx] | bus.req_wdata;
         end
      end
   end

endmodule
